// File: rtl/div_sqrt_mvp_issue_ctrl.sv
// Issue/response sequencer for the div/sqrt MVP unit.
// Holds one tagged request, starts the unit, and returns its result or a watchdog timeout.
module div_sqrt_mvp_issue_ctrl #(
  parameter int TAG_W        = 4,
  parameter int UNIT_OUT_DLY = 2,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             In_valid_SI,
  output logic             In_ready_SO,
  input  logic             In_op_SI,
  input  logic [63:0]      In_operand_a_DI,
  input  logic [63:0]      In_operand_b_DI,
  input  logic [2:0]       In_rm_SI,
  input  logic [5:0]       In_prec_SI,
  input  logic [1:0]       In_fmt_SI,
  input  logic [TAG_W-1:0] In_tag_DI,
  input  logic             Flush_SI,
  output logic             Div_start_SO,
  output logic             Sqrt_start_SO,
  output logic [63:0]      Operand_a_DO,
  output logic [63:0]      Operand_b_DO,
  output logic [2:0]       RM_SO,
  output logic [5:0]       Precision_ctl_SO,
  output logic [1:0]       Format_sel_SO,
  output logic             Kill_SO,
  input  logic [63:0]      Unit_result_DI,
  input  logic [4:0]       Unit_fflags_SI,
  input  logic             Unit_ready_SI,
  input  logic             Unit_done_SI,
  output logic             Out_valid_SO,
  input  logic             Out_ready_SI,
  output logic [63:0]      Out_result_DO,
  output logic [4:0]       Out_fflags_SO,
  output logic [TAG_W-1:0] Out_tag_DO,
  output logic             Out_timeout_SO,
  output logic             Busy_SO
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    HOLD
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] DRN_LEN  = 8'(UNIT_OUT_DLY);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             op_q, op_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic [2:0]       rm_q, rm_d;
  logic [5:0]       prec_q, prec_d;
  logic [1:0]       fmt_q, fmt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      res_q, res_d;
  logic [4:0]       flg_q, flg_d;
  logic             tmo_q, tmo_d;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rm_q    <= '0;
      prec_q  <= '0;
      fmt_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rm_q    <= rm_d;
      prec_q  <= prec_d;
      fmt_q   <= fmt_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rm_d          = rm_q;
    prec_d        = prec_q;
    fmt_d         = fmt_q;
    tag_d         = tag_q;
    res_d         = res_q;
    flg_d         = flg_q;
    tmo_d         = tmo_q;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    Kill_SO       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (In_valid_SI) begin
          op_d    = In_op_SI;
          a_d     = In_operand_a_DI;
          b_d     = In_operand_b_DI;
          rm_d    = In_rm_SI;
          prec_d  = In_prec_SI;
          fmt_d   = In_fmt_SI;
          tag_d   = In_tag_DI;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (Flush_SI) begin
          state_d = IDLE;
        end else if (Unit_ready_SI) begin
          Div_start_SO  = ~op_q;
          Sqrt_start_SO = op_q;
          cnt_d         = '0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // Unit ready is not trusted here: its delayed copy may still read 1.
        if (Flush_SI) begin
          Kill_SO = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = DRN_LEN;
          state_d = DRAIN;
        end else if (Unit_done_SI) begin
          res_d   = Unit_result_DI;
          flg_d   = Unit_fflags_SI;
          tmo_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == TMO_LAST) begin
          Kill_SO = 1'b1;
          pend_d  = 1'b1;
          cnt_d   = DRN_LEN;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 8'd0) begin
          if (pend_q) begin
            res_d   = '0;
            flg_d   = '0;
            tmo_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (Flush_SI || Out_ready_SI) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign In_ready_SO      = (state_q == IDLE) && !Rst_RI;
  assign Busy_SO          = (state_q != IDLE);
  assign Out_valid_SO     = (state_q == HOLD);
  assign Operand_a_DO     = a_q;
  assign Operand_b_DO     = b_q;
  assign RM_SO            = rm_q;
  assign Precision_ctl_SO = prec_q;
  assign Format_sel_SO    = fmt_q;
  assign Out_result_DO    = res_q;
  assign Out_fflags_SO    = flg_q;
  assign Out_tag_DO       = tag_q;
  assign Out_timeout_SO   = tmo_q;

endmodule
